baud_rate_controller: RTL
=========================

Name: baud_rate_controller

Overview:
Owns the UART oversampling tick (16x baud) and the bit tick (1x baud). It accepts new divisor settings from the config side over a valid/ready handshake. A new divisor is held in a shadow register and applied only when both the TX and RX engines report idle, so no frame ever straddles a baud change. It sits between the config register block and the TX/RX engines, which consume s_tick and bit_tick.

Parameters:
DIV_BITS, 11, width of the divisor counter and of the final-value registers.
DEFAULT_FINAL, 650, terminal count loaded at reset; tick period is DEFAULT_FINAL+1 clocks (100 MHz / (9600*16)). Must be at least 1.
OVERSAMPLE, 16, s_ticks per bit_tick; must be a power of two.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
run  input  1  tick generation enable.
cfg_valid  input  1  new divisor offered.
cfg_ready  output  1  controller can accept a divisor.
cfg_final  input  DIV_BITS  new terminal count.
tx_busy  input  1  TX engine mid-frame.
rx_busy  input  1  RX engine mid-frame.
s_tick  output  1  oversample tick, one-cycle pulse.
bit_tick  output  1  baud tick, one-cycle pulse coincident with every OVERSAMPLE-th s_tick.
active_final  output  DIV_BITS  terminal count currently in use.
cfg_pending  output  1  a shadow divisor is waiting to be applied.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=RUN, count=0, sub=0, active_final=DEFAULT_FINAL, shadow=0, cfg_pending=0, cfg_ready=1, s_tick=0, bit_tick=0.
- s_tick and bit_tick are forced to 0 in every cycle where rst=1.
- States:
  - RUN: cfg_ready=1. When cfg_valid&&cfg_ready, latch cfg_final into shadow and go to PEND.
  - PEND: cfg_ready=0, cfg_pending=1. The old divisor keeps running. If tx_busy=0 and rx_busy=0 in this cycle, go to APPLY; otherwise stay in PEND.
  - APPLY: lasts one cycle. active_final<=shadow, count<=0, sub<=0, cfg_pending<=0, s_tick forced 0. Go to RUN.
- Handshake latency: transfer in cycle T; PEND in T+1; APPLY in T+2 if both busy flags are low at T+1; new divisor is live with count=0 in T+3.
- cfg_valid during PEND or APPLY is not accepted. The requester holds cfg_valid and cfg_final until ready returns.
- Counter:
  - When run=1 and state!=APPLY: if count==active_final, count<=0; otherwise count<=count+1.
  - When run=0: count<=0 and sub<=0; the state machine keeps operating.
- Tick outputs:
  - s_tick = run && !rst && state!=APPLY && count==active_final (combinational from registers).
  - bit_tick = s_tick && sub==OVERSAMPLE-1. sub increments modulo OVERSAMPLE on each s_tick.
- Divisor arithmetic: count is DIV_BITS wide and never exceeds active_final, so there is no wrap-around; reload always goes to 0.
- cfg_final=0 is legal: s_tick is high every cycle while run=1, except in APPLY.
- Simultaneous events:
  - A handshake transfer in the same cycle as an s_tick: the tick is emitted with the old divisor.
  - Busy flags drop in the same cycle a new cfg_valid arrives while in PEND: the current shadow is applied first, and the new request is accepted in the following RUN cycle.
- Reset mid-operation: rst during PEND or APPLY discards the shadow, and active_final returns to DEFAULT_FINAL.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (RUN, PEND, APPLY);
  - the OVERSAMPLE constant;
  - the default divisor constant.
- One sub-module: baud_tick_counter. It contains count/sub, synchronous clear, the reload-at-terminal logic, and the s_tick/bit_tick decode, with inputs run, clear and final_value.
- baud_rate_controller holds the FSM, the shadow register and the handshake.

Test Plan:
1. DEFAULT_FINAL=3, rst released at cycle 0, run=1 -> s_tick at cycles 3, 7, 11, ...; first bit_tick at cycle 63; no s_tick while rst=1.
2. Busy flags low, cfg_final=7 transferred at T -> cfg_ready=0 at T+1, active_final=7 at T+3, first new s_tick at T+10, then every 8 cycles.
3. tx_busy=1 for 50 cycles after transfer -> period 4 continues, cfg_pending=1 throughout; APPLY occurs 1 cycle after tx_busy falls; rx_busy=1 alone produces the same stall.
4. Second request cfg_final=5 held during PEND -> not accepted until RUN; applied only after the first (7) is active.
5. run=0 for 10 cycles mid-count -> no ticks, count=0, sub=0; after run=1, first s_tick after active_final+1 cycles.
6. rst pulsed while in PEND with shadow=9 -> active_final=3, cfg_pending=0, cfg_ready=1 on the cycle after rst falls; divisor 9 is never applied.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART baud definitions: controller state encoding, oversample ratio and default divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } baud_state_t;

  localparam int UART_DIV_BITS      = 11;
  localparam int UART_OVERSAMPLE    = 16;
  localparam int UART_DEFAULT_FINAL = 650;  // 100 MHz / (9600 * 16) - 1

  function automatic int sub_width(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Divisor counter producing the 16x s_tick and the 1x bit_tick; ticks are combinational from count/sub.
// clear (divisor swap) and run=0 both zero count and sub and suppress s_tick for that cycle.
module baud_tick_counter
  import uart_pkg::*;
#(
  parameter int DIV_BITS   = UART_DIV_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                clear,
  input  logic [DIV_BITS-1:0] final_value,
  output logic                s_tick,
  output logic                bit_tick
);

  localparam int SUB_W = sub_width(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  logic [DIV_BITS-1:0] count;
  logic [SUB_W-1:0]    sub;
  logic                at_final;

  assign at_final = (count == final_value);
  assign s_tick   = run && !rst && !clear && at_final;
  assign bit_tick = s_tick && (sub == SUB_LAST);

  always_ff @(posedge clk) begin
    if (rst || !run || clear) begin
      count <= '0;
      sub   <= '0;
    end else if (at_final) begin
      count <= '0;
      sub   <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/baud_rate_controller.sv
// Baud tick owner: accepts a new divisor over valid/ready, parks it in a shadow register and
// swaps it in only while both TX and RX are idle; cfg_ready stays low from transfer until the swap completes.
module baud_rate_controller
  import uart_pkg::*;
#(
  parameter int DIV_BITS      = UART_DIV_BITS,
  parameter int DEFAULT_FINAL = UART_DEFAULT_FINAL,
  parameter int OVERSAMPLE    = UART_OVERSAMPLE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DIV_BITS-1:0] cfg_final,
  input  logic                tx_busy,
  input  logic                rx_busy,
  output logic                s_tick,
  output logic                bit_tick,
  output logic [DIV_BITS-1:0] active_final,
  output logic                cfg_pending
);

  baud_state_t         state;
  baud_state_t         state_nxt;
  logic [DIV_BITS-1:0] shadow;
  logic                accept;
  logic                apply;

  assign cfg_ready   = (state == RUN);
  assign cfg_pending = (state != RUN);
  assign accept      = cfg_valid && cfg_ready;
  assign apply       = (state == APPLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept) state_nxt = PEND;
      PEND:    if (!tx_busy && !rx_busy) state_nxt = APPLY;
      APPLY:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Shadow is only written from RUN, so a held request cannot overwrite a divisor awaiting the swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (accept) begin
      shadow <= cfg_final;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_final <= DIV_BITS'(DEFAULT_FINAL);
    end else if (apply) begin
      active_final <= shadow;
    end
  end

  baud_tick_counter #(
    .DIV_BITS   (DIV_BITS),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .clear       (apply),
    .final_value (active_final),
    .s_tick      (s_tick),
    .bit_tick    (bit_tick)
  );

endmodule
